// File: rtl/updown_sequencer.sv
// updown_sequencer: bounded up/down count controller.
// A start request captures the bounds, direction and mode. The block then
// steps the count once per cycle between lo and hi in one-shot, repeat or
// ping-pong fashion. hold pauses the sequence and stop aborts it.
module updown_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             dir_init,
    input  logic             hold,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             up_down,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] MODE_REPEAT = 2'b01;
    localparam logic [1:0] MODE_PING   = 2'b10;

    state_t           state;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic             dir_q;
    logic             terminal;

    // The count sits on the bound it is heading towards.
    assign terminal = up_down ? (count == hi_q) : (count == lo_q);

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            up_down <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
            mode_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            dir_q   <= 1'b0;
        end else begin
            // done and cfg_err are single-cycle pulses
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (lo <= hi) begin
                            mode_q  <= mode;
                            lo_q    <= lo;
                            hi_q    <= hi;
                            dir_q   <= dir_init;
                            count   <= dir_init ? lo : hi;
                            up_down <= dir_init;
                            busy    <= 1'b1;
                            state   <= RUN;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (!hold) begin
                        if (!terminal) begin
                            count <= up_down ? count + WIDTH'(1) : count - WIDTH'(1);
                        end else begin
                            case (mode_q)
                                MODE_REPEAT: begin
                                    // restart from the entry bound of this direction
                                    count <= up_down ? lo_q : hi_q;
                                end
                                MODE_PING: begin
                                    // turn around; a degenerate range only flips direction
                                    up_down <= ~up_down;
                                    if (lo_q != hi_q)
                                        count <= up_down ? count - WIDTH'(1) : count + WIDTH'(1);
                                end
                                default: begin
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    state <= DONE;
                                end
                            endcase
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // The latched initial direction is kept for visibility of the captured
    // configuration; the running direction lives in up_down.
    logic unused_dir;
    assign unused_dir = dir_q;

endmodule

// File: tb/tb_updown_sequencer.sv
// Bench for updown_sequencer: behavioural model compared every cycle, plus
// directed scenarios with hand-computed expectations and a random soak.
module tb_updown_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, dir_init, hold, stop;
    logic [1:0] mode;
    logic [3:0] lo, hi;
    logic [3:0] count;
    logic       up_down, busy, done, cfg_err;

    int checks = 0;
    int errors = 0;

    // model state: phase 0 idle, 1 running, 2 finishing
    int m_phase = 0;
    int m_cnt = 0;
    int m_up = 1;
    int m_cfg = 0;
    int m_mode = 0, m_lo = 0, m_hi = 0;

    updown_sequencer #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .lo(lo), .hi(hi),
        .dir_init(dir_init), .hold(hold), .stop(stop), .count(count),
        .up_down(up_down), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Advance the reference by one clock edge using the rules in plain terms.
    task automatic model_step(input int st, input int md, input int l, input int h,
                              input int d, input int hd, input int sp, input int rs);
        m_cfg = 0;
        if (rs) begin
            m_phase = 0; m_cnt = 0; m_up = 1;
            m_mode = 0; m_lo = 0; m_hi = 0;
        end else if (m_phase == 0) begin
            if (st) begin
                if (l <= h) begin
                    m_mode = md; m_lo = l; m_hi = h;
                    m_up = d;
                    m_cnt = d ? l : h;
                    m_phase = 1;
                end else begin
                    m_cfg = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (sp) m_phase = 2;
            else if (!hd) begin
                if (!(m_up ? m_cnt == m_hi : m_cnt == m_lo)) begin
                    m_cnt = m_cnt + (m_up ? 1 : -1);
                end else if (m_mode == 1) begin
                    m_cnt = m_up ? m_lo : m_hi;
                end else if (m_mode == 2) begin
                    m_up = 1 - m_up;
                    if (m_lo != m_hi) m_cnt = m_cnt + (m_up ? 1 : -1);
                end else begin
                    m_phase = 2;
                end
            end
        end else begin
            m_phase = 0;
        end
    endtask

    // Drive one cycle, advance the model and compare all outputs after the edge.
    task automatic cyc(input bit st, input bit [1:0] md, input bit [3:0] l, input bit [3:0] h,
                       input bit d, input bit hd, input bit sp, input bit rs);
        start = st; mode = md; lo = l; hi = h; dir_init = d; hold = hd; stop = sp; reset = rs;
        @(posedge clk);
        model_step(int'(st), int'(md), int'(l), int'(h), int'(d), int'(hd), int'(sp), int'(rs));
        #1;
        chk("count",   int'(count),   m_cnt);
        chk("up_down", int'(up_down), m_up);
        chk("busy",    int'(busy),    m_phase == 1 ? 1 : 0);
        chk("done",    int'(done),    m_phase == 2 ? 1 : 0);
        chk("cfg_err", int'(cfg_err), m_cfg);
    endtask

    task automatic idle_cyc();
        cyc(0, 2'b00, 4'd0, 4'd0, 0, 0, 0, 0);
    endtask

    initial begin
        start = 0; mode = 0; lo = 0; hi = 0; dir_init = 0; hold = 0; stop = 0; reset = 1;
        @(negedge clk);

        // reset state
        cyc(0, 2'b00, 4'd0, 4'd0, 0, 0, 0, 1);
        chk("rst_count", int'(count), 0);
        chk("rst_up", int'(up_down), 1);
        chk("rst_busy", int'(busy), 0);
        idle_cyc();

        // one-shot up 2..5
        cyc(1, 2'b00, 4'd2, 4'd5, 1, 0, 0, 0);
        chk("os_start", int'(count), 2);
        chk("os_busy", int'(busy), 1);
        idle_cyc(); chk("os_3", int'(count), 3);
        idle_cyc(); chk("os_4", int'(count), 4);
        idle_cyc(); chk("os_5", int'(count), 5);
        idle_cyc(); chk("os_done", int'(done), 1); chk("os_done_cnt", int'(count), 5);
        chk("os_done_busy", int'(busy), 0);
        idle_cyc(); chk("os_after_done", int'(done), 0); chk("os_hold_cnt", int'(count), 5);

        // repeat down 1..3, then stop at count 2
        cyc(1, 2'b01, 4'd1, 4'd3, 0, 0, 0, 0);
        chk("rp_start", int'(count), 3);
        idle_cyc(); chk("rp_2", int'(count), 2);
        idle_cyc(); chk("rp_1", int'(count), 1);
        idle_cyc(); chk("rp_reload", int'(count), 3); chk("rp_busy", int'(busy), 1);
        idle_cyc(); chk("rp_2b", int'(count), 2);
        cyc(0, 2'b00, 4'd0, 4'd0, 0, 0, 1, 0);
        chk("rp_stop_done", int'(done), 1); chk("rp_stop_cnt", int'(count), 2);
        idle_cyc();

        // ping-pong 2..4 with a 3-cycle hold at 3
        cyc(1, 2'b10, 4'd2, 4'd4, 1, 0, 0, 0);
        chk("pp_2", int'(count), 2);
        idle_cyc(); chk("pp_3", int'(count), 3);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 2'b00, 4'd0, 4'd0, 0, 1, 0, 0);
            chk("pp_hold", int'(count), 3); chk("pp_hold_up", int'(up_down), 1);
        end
        idle_cyc(); chk("pp_4", int'(count), 4); chk("pp_4_up", int'(up_down), 1);
        idle_cyc(); chk("pp_3d", int'(count), 3); chk("pp_3d_up", int'(up_down), 0);
        idle_cyc(); chk("pp_2d", int'(count), 2); chk("pp_2d_up", int'(up_down), 0);
        idle_cyc(); chk("pp_3u", int'(count), 3); chk("pp_3u_up", int'(up_down), 1);
        idle_cyc(); chk("pp_4u", int'(count), 4);
        cyc(0, 2'b00, 4'd0, 4'd0, 0, 0, 1, 0);
        idle_cyc();

        // bad config
        cyc(1, 2'b00, 4'd6, 4'd2, 1, 0, 0, 0);
        chk("ce_pulse", int'(cfg_err), 1); chk("ce_busy", int'(busy), 0);
        chk("ce_cnt", int'(count), 4);
        idle_cyc(); chk("ce_clear", int'(cfg_err), 0);

        // degenerate range, one-shot
        cyc(1, 2'b00, 4'd7, 4'd7, 1, 0, 0, 0);
        chk("eq_cnt", int'(count), 7);
        idle_cyc(); chk("eq_done", int'(done), 1); chk("eq_done_cnt", int'(count), 7);
        idle_cyc();

        // full range, one-shot down
        cyc(1, 2'b00, 4'd0, 4'd15, 0, 0, 0, 0);
        chk("full_start", int'(count), 15);
        for (int i = 0; i < 15; i++) idle_cyc();
        chk("full_zero", int'(count), 0); chk("full_busy", int'(busy), 1);
        idle_cyc(); chk("full_done", int'(done), 1); chk("full_nowrap", int'(count), 0);
        idle_cyc();

        // start during RUN is ignored
        cyc(1, 2'b00, 4'd2, 4'd5, 1, 0, 0, 0);
        cyc(1, 2'b01, 4'd0, 4'd9, 0, 0, 0, 0);
        chk("ign_3", int'(count), 3); chk("ign_up", int'(up_down), 1);
        idle_cyc(); idle_cyc();
        chk("ign_5", int'(count), 5);
        idle_cyc(); chk("ign_done", int'(done), 1);
        idle_cyc();

        // reset mid-run at count 3
        cyc(1, 2'b00, 4'd0, 4'd9, 1, 0, 0, 0);
        idle_cyc(); idle_cyc(); idle_cyc();
        chk("mr_3", int'(count), 3);
        cyc(1, 2'b00, 4'd0, 4'd9, 0, 1, 0, 1);
        chk("mr_cnt", int'(count), 0); chk("mr_up", int'(up_down), 1);
        chk("mr_busy", int'(busy), 0); chk("mr_done", int'(done), 0);

        // random soak against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(3) == 0), 2'($urandom_range(3)), 4'($urandom_range(15)),
                4'($urandom_range(15)), 1'($urandom_range(1)), ($urandom_range(5) == 0),
                ($urandom_range(24) == 0), ($urandom_range(149) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
